frame_ram_scheduler: RTL and testbench

FRAME_RAM_SCHEDULER -- requirements
Module: frame_ram_scheduler

---
 rtl/frame_ram_scheduler.sv | 98 +++++++++
 tb/tb_frame_ram_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_ram_scheduler.sv
// frame_ram_scheduler: sequences capture, corner finding and card isolation over one shared frame RAM
module frame_ram_scheduler #(
   parameter int ADDR_W  = 17,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 200000
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   input  logic              cam_we_in,
   input  logic [ADDR_W-1:0] cam_addr_in,
   input  logic [DATA_W-1:0] cam_data_in,
   input  logic              frame_done_in,
   output logic              fc_start_out,
   input  logic [ADDR_W-1:0] fc_addr_in,
   input  logic              fc_valid_in,
   input  logic [7:0]        fc_right_in,
   input  logic [7:0]        fc_left_in,
   input  logic [8:0]        fc_top_in,
   input  logic [8:0]        fc_bot_in,
   output logic              iso_start_out,
   input  logic [ADDR_W-1:0] iso_addr_in,
   input  logic              iso_done_in,
   output logic [ADDR_W-1:0] ram_addr_out,
   output logic [DATA_W-1:0] ram_din_out,
   output logic              ram_we_out,
   output logic [7:0]        right_edge_out,
   output logic [7:0]        left_edge_out,
   output logic [8:0]        top_edge_out,
   output logic [8:0]        bot_edge_out,
   output logic [2:0]        state_out,
   output logic              busy_out,
   output logic              done_out,
   output logic              error_out
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      CORNERS = 3'd2,
      ISOLATE = 3'd3,
      DONE    = 3'd4,
      ERROR   = 3'd5
   } state_t;
   state_t state, next_state;
   logic [CNT_W-1:0] cnt;
   logic timeout;
   logic edges_ok;
   assign timeout  = cnt == CNT_W'(TIMEOUT - 1);
   assign edges_ok = fc_left_in < fc_right_in && fc_top_in < fc_bot_in;
   // state register, per-phase cycle counter and edge latches
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state          <= IDLE;
         cnt            <= '0;
         right_edge_out <= '0;
         left_edge_out  <= '0;
         top_edge_out   <= '0;
         bot_edge_out   <= '0;
      end else begin
         state <= next_state;
         cnt   <= (next_state != state || !busy_out) ? '0 : cnt + 1'b1;
         if (state == CORNERS && fc_valid_in) begin
            right_edge_out <= fc_right_in;
            left_edge_out  <= fc_left_in;
            top_edge_out   <= fc_top_in;
            bot_edge_out   <= fc_bot_in;
         end
      end
   end
   // next state; exit events win over a same-cycle timeout
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = start_in ? CAPTURE : IDLE;
         CAPTURE: next_state = frame_done_in ? CORNERS : timeout ? ERROR : CAPTURE;
         CORNERS: next_state = fc_valid_in ? (edges_ok ? ISOLATE : ERROR) : timeout ? ERROR : CORNERS;
         ISOLATE: next_state = iso_done_in ? DONE : timeout ? ERROR : ISOLATE;
         DONE:    next_state = IDLE;
         ERROR:   next_state = start_in ? CAPTURE : ERROR;
         default: next_state = IDLE;
      endcase
   end
   // status, start pulses and RAM ownership decoded from the registered state
   always_comb begin
      state_out     = state;
      busy_out      = state == CAPTURE || state == CORNERS || state == ISOLATE;
      done_out      = state == DONE;
      error_out     = state == ERROR;
      fc_start_out  = state == CORNERS && cnt == '0;
      iso_start_out = state == ISOLATE && cnt == '0;
      ram_addr_out  = state == CAPTURE ? cam_addr_in :
                      state == CORNERS ? fc_addr_in  :
                      state == ISOLATE ? iso_addr_in : '0;
      ram_din_out   = state == CAPTURE ? cam_data_in : '0;
      ram_we_out    = state == CAPTURE && cam_we_in && rst_in;
   end
endmodule

// File: tb/tb_frame_ram_scheduler.sv
// tb_frame_ram_scheduler: vector table, corner sequences and randomized run against a reference model
module tb_frame_ram_scheduler;
   localparam int AW = 17;
   localparam int DW = 16;
   localparam int TO = 16;

   logic clk = 0;
   logic rst = 0;
   logic start = 0, cam_we = 0, frame_done = 0, fc_valid = 0, iso_done = 0;
   logic [AW-1:0] cam_addr = '0, fc_addr = '0, iso_addr = '0;
   logic [DW-1:0] cam_data = '0;
   logic [7:0] fc_right = '0, fc_left = '0;
   logic [8:0] fc_top = '0, fc_bot = '0;
   logic fc_start, iso_start, ram_we, busy, done, err;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [7:0] right_e, left_e;
   logic [8:0] top_e, bot_e;
   logic [2:0] state;

   frame_ram_scheduler #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk_in(clk), .rst_in(rst), .start_in(start),
      .cam_we_in(cam_we), .cam_addr_in(cam_addr), .cam_data_in(cam_data),
      .frame_done_in(frame_done), .fc_start_out(fc_start),
      .fc_addr_in(fc_addr), .fc_valid_in(fc_valid),
      .fc_right_in(fc_right), .fc_left_in(fc_left), .fc_top_in(fc_top), .fc_bot_in(fc_bot),
      .iso_start_out(iso_start), .iso_addr_in(iso_addr), .iso_done_in(iso_done),
      .ram_addr_out(ram_addr), .ram_din_out(ram_din), .ram_we_out(ram_we),
      .right_edge_out(right_e), .left_edge_out(left_e), .top_edge_out(top_e), .bot_edge_out(bot_e),
      .state_out(state), .busy_out(busy), .done_out(done), .error_out(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail = 0;

   // reference model: current phase, cycles spent in it, latched edges
   int m_state = 0;
   int m_elapsed = 0;
   logic [33:0] m_edges = '0;
   bit m_valid = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] flags();
      return {busy, done, err, fc_start, iso_start};
   endfunction

   function automatic logic [33:0] edges();
      return {right_e, left_e, top_e, bot_e};
   endfunction

   task automatic model_check();
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      bit ew;
      if (!m_valid) return;
      ea = m_state == 1 ? cam_addr : m_state == 2 ? fc_addr : m_state == 3 ? iso_addr : '0;
      ed = m_state == 1 ? cam_data : '0;
      ew = m_state == 1 && cam_we && rst;
      chk("m_state", state, m_state);
      chk("m_flags", flags(), {m_state >= 1 && m_state <= 3, m_state == 4, m_state == 5,
                               m_state == 2 && m_elapsed == 0, m_state == 3 && m_elapsed == 0});
      chk("m_ram_addr", ram_addr, ea);
      chk("m_ram_din", ram_din, ed);
      chk("m_ram_we", ram_we, ew);
      chk("m_edges", edges(), m_edges);
   endtask

   task automatic model_update();
      int nxt;
      bit tmo;
      if (!rst) begin
         m_state = 0;
         m_elapsed = 0;
         m_edges = '0;
         m_valid = 1;
         return;
      end
      if (!m_valid) return;
      tmo = m_elapsed + 1 >= TO;
      nxt = m_state;
      case (m_state)
         0: if (start) nxt = 1;
         1: nxt = frame_done ? 2 : tmo ? 5 : 1;
         2: begin
            if (fc_valid) begin
               m_edges = {fc_right, fc_left, fc_top, fc_bot};
               nxt = (fc_left < fc_right && fc_top < fc_bot) ? 3 : 5;
            end else if (tmo) nxt = 5;
         end
         3: nxt = iso_done ? 4 : tmo ? 5 : 3;
         4: nxt = 0;
         5: if (start) nxt = 1;
         default: nxt = 0;
      endcase
      m_elapsed = nxt == m_state ? m_elapsed + 1 : 0;
      m_state = nxt;
   endtask

   task automatic step();
      #3;
      model_check();
   endtask

   task automatic adv();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clear_inputs();
      start = 0; cam_we = 0; frame_done = 0; fc_valid = 0; iso_done = 0;
      cam_addr = '0; cam_data = '0; fc_addr = '0; iso_addr = '0;
      fc_right = '0; fc_left = '0; fc_top = '0; fc_bot = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 0;
      step();
      adv();
      rst = 1;
   endtask

   typedef struct {
      bit st, fd, fv, id;
      logic [7:0] r, l;
      logic [8:0] t, b;
      int es;
      logic [4:0] ef;
      logic [33:0] ee;
      bit ew;
   } vec_t;
   vec_t tv[$];

   function automatic vec_t mk(bit st, bit fd, bit fv, bit id, logic [7:0] l, logic [7:0] r,
                               logic [8:0] t, logic [8:0] b, int es, logic [4:0] ef,
                               logic [33:0] ee, bit ew);
      vec_t v;
      v.st = st; v.fd = fd; v.fv = fv; v.id = id;
      v.l = l; v.r = r; v.t = t; v.b = b;
      v.es = es; v.ef = ef; v.ee = ee; v.ew = ew;
      return v;
   endfunction

   localparam logic [33:0] E1 = {8'd180, 8'd50, 9'd40, 9'd260};
   localparam logic [33:0] E2 = {8'd100, 8'd120, 9'd40, 9'd260};

   initial begin
      // flags are {busy, done, error, fc_start, iso_start}
      tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, '0, 0));
      for (int i = 1; i <= 9; i++) tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b10000, '0, 1));
      tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 5'b10000, '0, 1));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 5'b10010, '0, 0));
      tv.push_back(mk(0, 0, 1, 0, 50, 180, 40, 260, 2, 5'b10000, '0, 0));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 5'b10001, E1, 0));
      tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3, 5'b10000, E1, 0));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 5'b01000, E1, 0));
      tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, E1, 0));
      tv.push_back(mk(0, 1, 1, 0, 7, 3, 0, 0, 1, 5'b10000, E1, 1));
      tv.push_back(mk(0, 0, 1, 0, 120, 100, 40, 260, 2, 5'b10010, E1, 0));
      tv.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 5, 5'b00100, E2, 0));
      tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5, 5'b00100, E2, 0));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b10000, E2, 1));

      do_reset();
      do_reset();
      step();
      chk("reset_state", state, 0);
      chk("reset_flags", flags(), 0);
      chk("reset_edges", edges(), 0);

      foreach (tv[i]) begin
         start = tv[i].st; frame_done = tv[i].fd; fc_valid = tv[i].fv; iso_done = tv[i].id;
         fc_left = tv[i].l; fc_right = tv[i].r; fc_top = tv[i].t; fc_bot = tv[i].b;
         cam_we = 1; cam_addr = AW'(i); cam_data = DW'(16'h100 + i);
         fc_addr = AW'(32'h2000 + i); iso_addr = AW'(32'h3000 + i);
         step();
         chk($sformatf("vec%0d_state", i), state, tv[i].es);
         chk($sformatf("vec%0d_flags", i), flags(), tv[i].ef);
         chk($sformatf("vec%0d_edges", i), edges(), tv[i].ee);
         chk($sformatf("vec%0d_we", i), ram_we, tv[i].ew);
         adv();
      end

      do_reset();
      start = 1; step(); adv(); start = 0;
      for (int i = 0; i < TO; i++) begin step(); chk("timeout_capture_hold", state, 1); adv(); end
      step();
      chk("timeout_capture_err", state, 5);
      start = 1; step(); adv(); start = 0;
      for (int i = 0; i < TO - 1; i++) begin step(); adv(); end
      frame_done = 1; step(); chk("exit_prio_before", state, 1); adv(); frame_done = 0;
      step();
      chk("exit_prio_after", state, 2);
      for (int i = 0; i < TO; i++) begin step(); chk("timeout_corners_hold", state, 2); adv(); end
      step();
      chk("timeout_corners_err", flags(), 5'b00100);

      do_reset();
      start = 1; step(); adv();
      step(); chk("start_busy_hold", state, 1); adv(); start = 0;
      frame_done = 1; step(); adv(); frame_done = 0;
      cam_we = 1; cam_addr = AW'(32'h1234); fc_addr = AW'(32'h0abc);
      step();
      chk("arb_we", ram_we, 0);
      chk("arb_addr", ram_addr, AW'(32'h0abc));
      fc_valid = 1; fc_left = 10; fc_right = 20; fc_top = 30; fc_bot = 40;
      adv(); fc_valid = 0;
      step(); chk("midrst_in_iso", state, 3);
      rst = 0; adv(); rst = 1;
      step();
      chk("midrst_state", state, 0);
      chk("midrst_flags", flags(), 0);
      chk("midrst_edges", edges(), 0);
      chk("midrst_ram", {ram_we, ram_addr, ram_din}, 0);
      start = 1; step(); adv(); start = 0;
      rst = 0; cam_we = 1; step();
      chk("rst_we_block", ram_we, 0);
      adv(); rst = 1;

      for (int n = 0; n < 3000; n++) begin
         rst = $urandom_range(0, 59) != 0;
         start = $urandom_range(0, 5) == 0;
         frame_done = $urandom_range(0, 9) == 0;
         fc_valid = $urandom_range(0, 9) == 0;
         iso_done = $urandom_range(0, 9) == 0;
         cam_we = $urandom_range(0, 1) == 1;
         cam_addr = AW'($urandom); cam_data = DW'($urandom);
         fc_addr = AW'($urandom); iso_addr = AW'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            fc_left = 8'($urandom_range(0, 127)); fc_right = 8'($urandom_range(128, 255));
            fc_top = 9'($urandom_range(0, 255)); fc_bot = 9'($urandom_range(256, 511));
         end else begin
            fc_left = 8'($urandom); fc_right = 8'($urandom);
            fc_top = 9'($urandom); fc_bot = 9'($urandom);
         end
         step();
         adv();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
